as_gpio: RTL and testbench

AS_GPIO -- requirements
Module: as_gpio

---
 rtl/as_pack.sv | 31 +++
 rtl/as_gpio_sync2.sv | 25 ++
 rtl/as_gpio.sv | 137 +++++++++++++
 tb/tb_as_gpio.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// Shared constants and types for the AS peripheral set; this slice adds the GPIO
// register map (offsets, register count and register-index enum).
package as_pack;

  localparam int reg_width       = 64;
  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 4;
  localparam int gpio_nr_regs_c  = 7;

  localparam logic [reg_width-1:0] gpio_id_reg_addr_rst_c = 64'h1;

  localparam logic [5:0] gpio_id_off_c   = 6'h00;
  localparam logic [5:0] gpio_dir_off_c  = 6'h08;
  localparam logic [5:0] gpio_data_off_c = 6'h10;
  localparam logic [5:0] gpio_ris_off_c  = 6'h18;
  localparam logic [5:0] gpio_imsc_off_c = 6'h20;
  localparam logic [5:0] gpio_mis_off_c  = 6'h28;
  localparam logic [5:0] gpio_icr_off_c  = 6'h30;

  // Register index is the byte offset divided by eight.
  typedef enum logic [2:0] {
    GPIO_REG_ID   = 3'd0,
    GPIO_REG_DIR  = 3'd1,
    GPIO_REG_DATA = 3'd2,
    GPIO_REG_RIS  = 3'd3,
    GPIO_REG_IMSC = 3'd4,
    GPIO_REG_MIS  = 3'd5,
    GPIO_REG_ICR  = 3'd6
  } gpio_reg_e;

endpackage

// File: rtl/as_gpio_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous pad inputs.
module as_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, giving a true two-stage pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/as_gpio.sv
// GPIO block: 64-bit register window, direction/output registers, synchronized inputs.
// Rising-edge interrupts (RIS/IMSC/MIS/ICR, irq) exist only when GPIO_IRQ_EN is defined.
module as_gpio
  import as_pack::*;
#(
  parameter int NR_GPIOS = nr_gpios,
  parameter int ADDR_W   = gpio_addr_width + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [reg_width-1:0] wdata,
  output logic [reg_width-1:0] rdata,
  output logic                 rvalid,
  input  logic [NR_GPIOS-1:0]  gpio_in,
  output logic [NR_GPIOS-1:0]  gpio_out,
  output logic [NR_GPIOS-1:0]  gpio_oe,
  output logic                 irq
);

  localparam int IDX_W = ADDR_W - 3;

  logic [IDX_W-1:0]    idx;
  logic                hit;
  gpio_reg_e           reg_sel;
  logic                wr;
  logic                rd;
  logic [NR_GPIOS-1:0] wval;
  logic [NR_GPIOS-1:0] dir_q;
  logic [NR_GPIOS-1:0] out_q;
  logic [NR_GPIOS-1:0] gpio_sync;
  logic [NR_GPIOS-1:0] ris;
  logic [NR_GPIOS-1:0] imsc;
  logic [NR_GPIOS-1:0] mis;
  logic [reg_width-1:0] rd_val;
  logic                unused_bits;

  assign idx     = addr[ADDR_W-1:3];
  assign hit     = idx < IDX_W'(gpio_nr_regs_c);
  assign reg_sel = gpio_reg_e'(idx[2:0]);
  assign wr      = cs & we & hit;
  // Write wins over a simultaneous read; such a read is dropped.
  assign rd      = cs & re & ~we;
  assign wval    = wdata[NR_GPIOS-1:0];

  assign unused_bits = ^{addr[2:0], wdata[reg_width-1:NR_GPIOS]};

  as_sync2 #(.WIDTH(NR_GPIOS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (gpio_sync)
  );

  // NOTE: every flop here is cleared by the async reset; there is no memory array,
  // so nothing is left uninitialized after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= '0;
      out_q <= '0;
    end else if (wr) begin
      if (reg_sel == GPIO_REG_DIR)  dir_q <= wval;
      if (reg_sel == GPIO_REG_DATA) out_q <= wval;
    end
  end

  assign gpio_oe  = dir_q;
  assign gpio_out = out_q;

`ifdef GPIO_IRQ_EN
  logic [NR_GPIOS-1:0] prev_q;
  logic [NR_GPIOS-1:0] ris_q;
  logic [NR_GPIOS-1:0] imsc_q;
  logic [NR_GPIOS-1:0] edge_det;
  logic [NR_GPIOS-1:0] icr_clr;
  logic                irq_q;

  // Output pins never raise edges; an edge beats a same-cycle ICR clear.
  assign edge_det = gpio_sync & ~prev_q & ~dir_q;
  assign icr_clr  = (wr && reg_sel == GPIO_REG_ICR) ? wval : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ris_q  <= '0;
      imsc_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= gpio_sync;
      ris_q  <= (ris_q & ~icr_clr) | edge_det;
      if (wr && reg_sel == GPIO_REG_IMSC) imsc_q <= wval;
      irq_q  <= |(ris_q & imsc_q);
    end
  end

  assign ris  = ris_q;
  assign imsc = imsc_q;
  assign mis  = ris_q & imsc_q;
  assign irq  = irq_q;
`else
  assign ris  = '0;
  assign imsc = '0;
  assign mis  = '0;
  assign irq  = 1'b0;
`endif

  // NOTE: rd_val gets a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational (no latch).
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (reg_sel)
        GPIO_REG_ID:   rd_val = gpio_id_reg_addr_rst_c;
        GPIO_REG_DIR:  rd_val[NR_GPIOS-1:0] = dir_q;
        GPIO_REG_DATA: rd_val[NR_GPIOS-1:0] = (dir_q & out_q) | (~dir_q & gpio_sync);
        GPIO_REG_RIS:  rd_val[NR_GPIOS-1:0] = ris;
        GPIO_REG_IMSC: rd_val[NR_GPIOS-1:0] = imsc;
        GPIO_REG_MIS:  rd_val[NR_GPIOS-1:0] = mis;
        default:       rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_as_gpio.sv
// Randomized self-checking bench for as_gpio against a cycle-level register model.
// Define GPIO_IRQ_EN for both bench and RTL to exercise the interrupt build.
module tb_as_gpio;

`ifdef GPIO_IRQ_EN
  localparam bit irq_en = 1'b1;
`else
  localparam bit irq_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0, we = 1'b0, re = 1'b0;
  logic [5:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        rvalid;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Model state: registers plus the last three sampled pad values (h0 newest).
  logic [7:0]  m_dir, m_out, m_ris, m_imsc;
  logic [7:0]  m_h0, m_h1, m_h2;
  logic        m_irq, m_rvalid;
  logic [63:0] m_rdata;

  as_gpio dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = '0; m_out = '0; m_ris = '0; m_imsc = '0;
    m_h0 = '0; m_h1 = '0; m_h2 = '0;
    m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // Synchronized pin value is the pad sampled two edges ago (h1).
  function automatic logic [63:0] model_read(input int ri);
    logic [7:0] v;
    case (ri)
      0: return 64'h1;
      1: v = m_dir;
      2: v = (m_dir & m_out) | (~m_dir & m_h1);
      3: v = m_ris;
      4: v = m_imsc;
      5: v = m_ris & m_imsc;
      default: v = '0;
    endcase
    return {56'h0, v};
  endfunction

  task automatic compare_outputs();
    check("gpio_oe", gpio_oe, m_dir);
    check("gpio_out", gpio_out, m_out);
    check("irq", irq, m_irq);
    check("rvalid", rvalid, m_rvalid);
    check("rdata", rdata, m_rdata);
  endtask

  // Advance model by one edge using the current inputs, then clock the DUT and compare.
  task automatic tick();
    int         ri;
    bit         wr, rd;
    logic [7:0] rise, clr, nxt_ris;
    logic       nxt_irq;
    if (!rst_n) begin
      model_reset();
    end else begin
      ri      = int'(addr[5:3]);
      wr      = cs && we;
      rd      = cs && re && !we;
      rise    = irq_en ? (m_h1 & ~m_h2 & ~m_dir) : 8'h00;
      clr     = (wr && ri == 6) ? wdata[7:0] : 8'h00;
      nxt_ris = (m_ris & ~clr) | rise;
      nxt_irq = irq_en && ((m_ris & m_imsc) != 0);
      if (rd) m_rdata = model_read(ri);
      m_rvalid = rd;
      if (wr && ri == 1) m_dir = wdata[7:0];
      if (wr && ri == 2) m_out = wdata[7:0];
      if (wr && ri == 4 && irq_en) m_imsc = wdata[7:0];
      m_ris = nxt_ris;
      m_irq = nxt_irq;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = gpio_in;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic bus(input bit w, input bit r, input logic [5:0] a, input logic [63:0] d);
    cs = 1'b1; we = w; re = r; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stim
    int seen;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset state and ID read.
    check("reset_oe", gpio_oe, 64'h0);
    check("reset_irq", irq, 64'h0);
    bus(1'b0, 1'b1, 6'h00, '0);
    check("id_rvalid", rvalid, 64'h1);
    check("id_rdata", rdata, 64'h1);
    tick();
    check("rvalid_one_cycle", rvalid, 64'h0);

    // Output path.
    bus(1'b1, 1'b0, 6'h08, 64'hFF);
    bus(1'b1, 1'b0, 6'h10, 64'hA5);
    check("out_oe", gpio_oe, 64'hFF);
    check("out_val", gpio_out, 64'hA5);
    bus(1'b0, 1'b1, 6'h13, '0);
    check("out_read", rdata, 64'hA5);

    // Write beats read when both strobes are set.
    bus(1'b1, 1'b1, 6'h10, 64'h5A);
    check("collide_rvalid", rvalid, 64'h0);
    check("collide_write", gpio_out, 64'h5A);

    // Input path through the synchronizer.
    bus(1'b1, 1'b0, 6'h08, 64'h00);
    gpio_in = 8'h3C;
    idle(3);
    bus(1'b0, 1'b1, 6'h10, '0);
    check("in_read", rdata, 64'h3C);

    // Interrupt: clear pending state, unmask bit 0, raise gpio_in[0].
    gpio_in = 8'h00;
    idle(4);
    bus(1'b1, 1'b0, 6'h30, 64'hFF);
    bus(1'b1, 1'b0, 6'h20, 64'h01);
    gpio_in = 8'h01;
    seen = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (irq && seen == 0) seen = i;
    end
    check("irq_within_4", seen != 0, irq_en);
    bus(1'b0, 1'b1, 6'h18, '0);
    check("ris_bit0", rdata, {63'h0, irq_en});
    bus(1'b0, 1'b1, 6'h28, '0);
    check("mis_bit0", rdata, {63'h0, irq_en});
    bus(1'b1, 1'b0, 6'h30, 64'h01);
    tick();
    check("irq_cleared", irq, 64'h0);

    // ICR write on the very edge that captures a bit-1 rising edge.
    gpio_in = 8'h03;
    tick();
    tick();
    bus(1'b1, 1'b0, 6'h30, 64'h02);
    bus(1'b0, 1'b1, 6'h18, '0);
    check("collision_ris1", rdata[1], irq_en);
    check("icr_reads_zero", model_read(6), 64'h0);
    bus(1'b0, 1'b1, 6'h30, '0);
    check("icr_read", rdata, 64'h0);

    // Unmapped offset reads zero and ignores writes.
    bus(1'b1, 1'b0, 6'h38, 64'hFF);
    bus(1'b0, 1'b1, 6'h3F, '0);
    check("unmapped_read", rdata, 64'h0);

    // All pins unmasked while toggling: irq only in the interrupt build.
    bus(1'b1, 1'b0, 6'h20, 64'hFF);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      gpio_in = ~gpio_in;
      tick();
      if (irq) seen = 1;
    end
    check("toggle_irq", seen, irq_en);

    // Reset mid-read: rvalid drops immediately and nothing follows release.
    bus(1'b1, 1'b0, 6'h08, 64'h0F);
    cs = 1'b1; re = 1'b1; addr = 6'h08;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rvalid", rvalid, 64'h0);
    check("rst_oe", gpio_oe, 64'h0);
    check("rst_irq", irq, 64'h0);
    cs = 1'b0; re = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rvalid", rvalid, 64'h0);

    // Randomized register traffic and pad activity.
    for (int i = 0; i < 400; i++) begin
      cs    = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1);
      re    = $urandom_range(0, 1);
      addr  = 6'($urandom_range(0, 63));
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) gpio_in = 8'($urandom);
      tick();
    end
    cs = 1'b0; we = 1'b0; re = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
